// File: rtl/cp0_exc_redirect_pkg.sv
// Shared definitions for the CP0 exception/ERET redirect controller:
// the BEV=1 general exception vector, the ExcCode values WB can report,
// and the controller state encoding.
package cp0_exc_redirect_pkg;

  localparam logic [31:0] EXC_VECTOR_BEV = 32'hBFC0_0380;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REDIR = 2'd2
  } state_e;

endpackage

// File: rtl/cp0_exc_redirect_hold.sv
// exc_redirect_hold: holds the redirect target and the valid flag offered
// to IF, and performs the valid/ready handshake.
//   clk, rst        clock, async active-high reset
//   capture_i       load capture_pc_i as the new target (request accept)
//   capture_pc_i    target to latch
//   offer_i         raise redir_valid_o on the next edge
//   redir_ready_i   IF accepts the redirect
//   redir_valid_o   redirect offered
//   redir_pc_o      target, stable while redir_valid_o
//   fire_o          handshake completes this cycle
module exc_redirect_hold
  import cp0_exc_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC = EXC_VECTOR_BEV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_i,
  input  logic [31:0] capture_pc_i,
  input  logic        offer_i,
  input  logic        redir_ready_i,
  output logic        redir_valid_o,
  output logic [31:0] redir_pc_o,
  output logic        fire_o
);

  logic        valid_q;
  logic [31:0] pc_q;

  assign fire_o        = valid_q & redir_ready_i;
  assign redir_valid_o = valid_q;
  assign redir_pc_o    = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
    end else begin
      if (capture_i) pc_q <= capture_pc_i;
      if (offer_i) valid_q <= 1'b1;
      else if (fire_o) valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/cp0_exc_redirect.sv
// cp0_exc_redirect: accepts exception / ERET requests from WB, emits the
// one-cycle CP0 strobes, flushes the pipeline and hands IF a redirect PC.
//   exc_req/exc_pc/exc_bd/exc_code  exception request from WB
//   eret_req, cp0_epc_data          ERET request and current EPC
//   cp0_status_exl                  Status.EXL (does not affect target)
//   exception/exc_bd_o/exc_pc_o/cause_code  CP0 exception update
//   exl_clr                         CP0 EXL clear strobe (ERET)
//   flush                           kill IF..MEM
//   redir_valid/redir_pc/redir_ready  redirect handshake with IF
//   busy                            controller not idle; WB stalls commits
module cp0_exc_redirect
  import cp0_exc_redirect_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_BEV,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [4:0]  exc_code,
  input  logic        eret_req,
  input  logic [31:0] cp0_epc_data,
  input  logic        cp0_status_exl,
  output logic        exception,
  output logic        exc_bd_o,
  output logic [31:0] exc_pc_o,
  output logic [4:0]  cause_code,
  output logic        exl_clr,
  output logic        flush,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ready,
  output logic        busy
);

  localparam int unsigned       CNT_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              exception_q;
  logic              exl_clr_q;
  logic              flush_q;
  logic              bd_q;
  logic [31:0]       pc_q;
  logic [4:0]        code_q;

  logic              accept_exc;
  logic              accept_eret;
  logic              capture;
  logic [31:0]       capture_pc;
  logic              offer;
  logic              fire;

  // EXL only matters to CP0 (EPC hold); the redirect target ignores it.
  logic unused_exl;
  assign unused_exl = cp0_status_exl;

  // Exception has priority over a simultaneous ERET.
  assign accept_exc  = (state_q == ST_IDLE) && exc_req;
  assign accept_eret = (state_q == ST_IDLE) && eret_req && !exc_req;
  assign capture     = accept_exc || accept_eret;
  assign capture_pc  = accept_exc ? EXC_VECTOR : cp0_epc_data;

  // flush rises on the first FLUSH edge; the counter then tracks completed
  // flush cycles so the redirect is offered after exactly FLUSH_CYCLES of them.
  assign offer = (state_q == ST_FLUSH) && flush_q && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      exception_q <= 1'b0;
      exl_clr_q   <= 1'b0;
      flush_q     <= 1'b0;
      bd_q        <= 1'b0;
      pc_q        <= '0;
      code_q      <= '0;
    end else begin
      exception_q <= 1'b0;
      exl_clr_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (accept_exc) begin
            exception_q <= 1'b1;
            pc_q        <= exc_pc;
            bd_q        <= exc_bd;
            code_q      <= exc_code;
            state_q     <= ST_FLUSH;
          end else if (accept_eret) begin
            exl_clr_q <= 1'b1;
            state_q   <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          flush_q <= 1'b1;
          if (flush_q) begin
            if (cnt_q == CNT_LAST) state_q <= ST_REDIR;
            else cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_REDIR: begin
          if (fire) begin
            flush_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  exc_redirect_hold #(
    .RESET_PC(EXC_VECTOR)
  ) u_hold (
    .clk          (clk),
    .rst          (rst),
    .capture_i    (capture),
    .capture_pc_i (capture_pc),
    .offer_i      (offer),
    .redir_ready_i(redir_ready),
    .redir_valid_o(redir_valid),
    .redir_pc_o   (redir_pc),
    .fire_o       (fire)
  );

  assign exception  = exception_q;
  assign exl_clr    = exl_clr_q;
  assign exc_bd_o   = bd_q;
  assign exc_pc_o   = pc_q;
  assign cause_code = code_q;
  assign flush      = flush_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cp0_exc_redirect.sv
module tb_cp0_exc_redirect;

  localparam logic [31:0] EV = 32'hBFC0_0380;
  localparam int unsigned FC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_req, exc_bd, eret_req, cp0_status_exl, redir_ready;
  logic [31:0] exc_pc, cp0_epc_data;
  logic [4:0]  exc_code;
  logic        exception, exc_bd_o, exl_clr, flush, redir_valid, busy;
  logic [31:0] exc_pc_o, redir_pc;
  logic [4:0]  cause_code;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic        is_exc;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  code;
  } strobe_t;

  strobe_t     sq[$];
  logic [31:0] tq[$];

  always #5 clk = ~clk;

  cp0_exc_redirect #(
    .EXC_VECTOR  (EV),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .exc_req       (exc_req),
    .exc_pc        (exc_pc),
    .exc_bd        (exc_bd),
    .exc_code      (exc_code),
    .eret_req      (eret_req),
    .cp0_epc_data  (cp0_epc_data),
    .cp0_status_exl(cp0_status_exl),
    .exception     (exception),
    .exc_bd_o      (exc_bd_o),
    .exc_pc_o      (exc_pc_o),
    .cause_code    (cause_code),
    .exl_clr       (exl_clr),
    .flush         (flush),
    .redir_valid   (redir_valid),
    .redir_pc      (redir_pc),
    .redir_ready   (redir_ready),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Drives one request, follows it through strobe,
  // flush and redirect, holding ready low for wait_cyc cycles.
  task automatic run_event(input logic exc, input logic eret, input logic [31:0] pc,
                           input logic bd, input logic [4:0] code, input logic [31:0] epc,
                           input logic exl, input int unsigned wait_cyc, input logic spam);
    strobe_t     s;
    strobe_t     e;
    logic [31:0] t;
    int unsigned edges;
    int unsigned fl;
    exc_req = exc; eret_req = eret; exc_pc = pc; exc_bd = bd; exc_code = code;
    cp0_epc_data = epc; cp0_status_exl = exl;
    e.is_exc = exc; e.pc = pc; e.bd = bd; e.code = code;
    sq.push_back(e);
    tq.push_back(exc ? EV : epc);
    @(negedge clk);
    exc_req = 1'b0; eret_req = 1'b0;
    cp0_epc_data = 32'hDEAD_BEE0;   // later EPC changes must not move the target
    s = sq.pop_front();
    check("exception_strobe", exception, s.is_exc);
    check("exl_clr_strobe", exl_clr, !s.is_exc);
    if (s.is_exc) begin
      check("exc_pc_o", exc_pc_o, s.pc);
      check("exc_bd_o", exc_bd_o, s.bd);
      check("cause_code", cause_code, s.code);
    end
    check("busy_after_accept", busy, 1'b1);
    edges = 1; fl = 0;
    while (!redir_valid && edges < 20) begin
      @(negedge clk);
      edges++;
      if (edges == 2) begin
        check("exception_width", exception, 1'b0);
        check("exl_clr_width", exl_clr, 1'b0);
      end
      if (flush && !redir_valid) fl++;
    end
    check("redir_latency", edges - 1, FC + 1);
    check("flush_cycles", fl, FC);
    t = tq.pop_front();
    for (int i = 0; i < int'(wait_cyc); i++) begin
      check("bp_valid", redir_valid, 1'b1);
      check("bp_pc", redir_pc, t);
      check("bp_busy", busy, 1'b1);
      check("bp_flush", flush, 1'b1);
      check("bp_no_strobe", exception, 1'b0);
      if (spam) begin
        exc_req = 1'b1; exc_code = 5'h04; exc_pc = 32'h1234_5678;
      end
      @(negedge clk);
    end
    exc_req = 1'b0;
    check("redir_pc", redir_pc, t);
    check("redir_valid", redir_valid, 1'b1);
    redir_ready = 1'b1;
    @(negedge clk);
    redir_ready = 1'b0;
    check("valid_drop", redir_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_flush", flush, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    exc_req = 0; exc_bd = 0; eret_req = 0; cp0_status_exl = 0; redir_ready = 0;
    exc_pc = '0; cp0_epc_data = '0; exc_code = '0;
    repeat (2) @(negedge clk);
    check("rst_exception", exception, 1'b0);
    check("rst_exl_clr", exl_clr, 1'b0);
    check("rst_flush", flush, 1'b0);
    check("rst_valid", redir_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_redir_pc", redir_pc, EV);
    check("rst_exc_pc_o", exc_pc_o, 32'h0);
    check("rst_cause", cause_code, 5'h0);
    rst = 1'b0;
    @(negedge clk);

    // Plain exception
    run_event(1'b1, 1'b0, 32'h8000_1000, 1'b0, 5'h0C, 32'h0, 1'b0, 0, 1'b0);
    // ERET; accepted in the first idle cycle after the previous handshake
    run_event(1'b0, 1'b1, 32'h0, 1'b0, 5'h0, 32'h8000_2004, 1'b1, 1, 1'b0);
    // Simultaneous exception and ERET: exception wins
    run_event(1'b1, 1'b1, 32'h8000_3000, 1'b0, 5'h08, 32'h8000_4444, 1'b0, 0, 1'b0);
    // Backpressure with a spurious exception request during REDIR
    run_event(1'b1, 1'b0, 32'h8000_5000, 1'b0, 5'h0A, 32'h0, 1'b0, 5, 1'b1);
    check("spam_ignored", exception, 1'b0);
    // Branch-delay exception with EXL already set
    run_event(1'b1, 1'b0, 32'h8000_0010, 1'b1, 5'h09, 32'h8000_7770, 1'b1, 2, 1'b0);
    // Misaligned EPC passes through untouched
    run_event(1'b0, 1'b1, 32'h0, 1'b0, 5'h0, 32'h8000_2006, 1'b1, 0, 1'b0);

    // Reset asserted mid-FLUSH, away from any clock edge
    exc_req = 1'b1; exc_pc = 32'h8000_9000; exc_code = 5'h0C; exc_bd = 1'b0;
    @(negedge clk);
    exc_req = 1'b0;
    @(negedge clk);
    check("pre_rst_flush", flush, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_flush", flush, 1'b0);
    check("arst_valid", redir_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_redir_pc", redir_pc, EV);
    check("arst_exc_pc_o", exc_pc_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_exception", exception, 1'b0);
      check("post_rst_exl_clr", exl_clr, 1'b0);
      check("post_rst_valid", redir_valid, 1'b0);
    end
    run_event(1'b0, 1'b1, 32'h0, 1'b0, 5'h0, 32'h8000_A008, 1'b1, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
